// File: rtl/gpu_raster.sv
// gpu_raster: command-driven pixel rasteriser for a FB_WIDTH x FB_HEIGHT framebuffer.
//   Commands FILL / POINT / RECT emit a clipped rectangle in row-major order;
//   LINE emits a Bresenham line (only when RASTER_LINE_EN is defined; otherwise
//   LINE completes with no pixels after a single busy cycle).
// Ports:
//   clk, rst_async                 clock, asynchronous active-high reset
//   gpu_command, gpu_x0/y0/x1/y1,  command and operands, latched when
//   gpu_colour, gpu_execute_request  gpu_execute_request is seen while idle
//   gpu_busy                       high while a command is in progress
//   fb_x, fb_y, fb_colour, fb_write  pixel write; held while fb_ready is low
//   fb_ready                       framebuffer accepts the write this cycle
// Build option: define RASTER_LINE_EN to include the line-stepping datapath.

package common;
   typedef enum logic [1:0] {
      RASTER_CMD_FILL  = 2'd0,
      RASTER_CMD_POINT = 2'd1,
      RASTER_CMD_LINE  = 2'd2,
      RASTER_CMD_RECT  = 2'd3
   } raster_command_t;
endpackage

module gpu_raster
   import common::*;
#(
   parameter int unsigned FB_WIDTH  = 214,
   parameter int unsigned FB_HEIGHT = 160
) (
   input  logic            clk,
   input  logic            rst_async,
   input  raster_command_t gpu_command,
   input  logic [7:0]      gpu_x0,
   input  logic [7:0]      gpu_y0,
   input  logic [7:0]      gpu_x1,
   input  logic [7:0]      gpu_y1,
   input  logic [2:0]      gpu_colour,
   input  logic            gpu_execute_request,
   output logic            gpu_busy,
   output logic [7:0]      fb_x,
   output logic [7:0]      fb_y,
   output logic [2:0]      fb_colour,
   output logic            fb_write,
   input  logic            fb_ready
);
   localparam int unsigned CW = 9;
   localparam int unsigned EW = 12;
   localparam logic [CW-1:0] X_LAST = CW'(FB_WIDTH - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(FB_HEIGHT - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_AREA = 2'd1, ST_LINE = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          busy_q;
   logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [CW-1:0] x_min_q, x_min_d, x_end_q, x_end_d, y_end_q, y_end_d;
   logic [2:0]    colour_q, colour_d;
   logic          write_q, write_d;

   logic [CW-1:0] x0_c, y0_c, x1_c, y1_c;
   logic [CW-1:0] ax_lo_c, ax_hi_c, ay_lo_c, ay_hi_c;
   logic          area_empty_c, at_end_c;

   assign x0_c = CW'(gpu_x0);
   assign y0_c = CW'(gpu_y0);
   assign x1_c = CW'(gpu_x1);
   assign y1_c = CW'(gpu_y1);

   // Request area decode, clipped on the high side (coordinates are unsigned)
   always_comb begin
      ax_lo_c = (x0_c < x1_c) ? x0_c : x1_c;
      ax_hi_c = (x0_c < x1_c) ? x1_c : x0_c;
      ay_lo_c = (y0_c < y1_c) ? y0_c : y1_c;
      ay_hi_c = (y0_c < y1_c) ? y1_c : y0_c;
      case (gpu_command)
         RASTER_CMD_FILL: begin
            ax_lo_c = '0;   ax_hi_c = X_LAST;
            ay_lo_c = '0;   ay_hi_c = Y_LAST;
         end
         RASTER_CMD_POINT: begin
            ax_lo_c = x0_c; ax_hi_c = x0_c;
            ay_lo_c = y0_c; ay_hi_c = y0_c;
         end
         default: ;
      endcase
      area_empty_c = (ax_lo_c > X_LAST) || (ay_lo_c > Y_LAST);
      if (ax_hi_c > X_LAST) ax_hi_c = X_LAST;
      if (ay_hi_c > Y_LAST) ay_hi_c = Y_LAST;
   end

   // Current pixel is the last one of the area / the line end point
   assign at_end_c = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);

`ifdef RASTER_LINE_EN
   logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic signed [EW-1:0] adx_c, ady_c, e2_c, err_step_c;
   logic [CW-1:0]        step_x_c, step_y_c;
   logic                 line_adv_c;

   assign adx_c = (x1_c >= x0_c) ? EW'(x1_c - x0_c) : EW'(x0_c - x1_c);
   assign ady_c = (y1_c >= y0_c) ? EW'(y1_c - y0_c) : EW'(y0_c - y1_c);
   // Clipped points are stepped over without waiting for fb_ready
   assign line_adv_c = !write_q || fb_ready;

   // One Bresenham step (dy held negative, err = dx + dy initially)
   always_comb begin
      e2_c       = err_q <<< 1;
      err_step_c = err_q;
      step_x_c   = cur_x_q;
      step_y_c   = cur_y_q;
      if (e2_c >= dy_q) begin
         err_step_c = err_step_c + dy_q;
         step_x_c   = sx_neg_q ? cur_x_q - CW'(1) : cur_x_q + CW'(1);
      end
      if (e2_c <= dx_q) begin
         err_step_c = err_step_c + dx_q;
         step_y_c   = sy_neg_q ? cur_y_q - CW'(1) : cur_y_q + CW'(1);
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gpu_execute_request)
            state_d = (gpu_command == RASTER_CMD_LINE) ? ST_LINE : ST_AREA;
         ST_AREA: if (!write_q || (fb_ready && at_end_c)) state_d = ST_IDLE;
`ifdef RASTER_LINE_EN
         ST_LINE: if (line_adv_c && at_end_c) state_d = ST_IDLE;
`else
         ST_LINE: state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      x_min_d  = x_min_q;
      x_end_d  = x_end_q;
      y_end_d  = y_end_q;
      colour_d = colour_q;
      write_d  = write_q;
`ifdef RASTER_LINE_EN
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
`endif
      case (state_q)
         ST_IDLE: begin
            write_d = 1'b0;
            if (gpu_execute_request) begin
               colour_d = gpu_colour;
               if (gpu_command == RASTER_CMD_LINE) begin
                  cur_x_d = x0_c;
                  cur_y_d = y0_c;
                  x_min_d = x0_c;
                  x_end_d = x1_c;
                  y_end_d = y1_c;
`ifdef RASTER_LINE_EN
                  dx_d     = adx_c;
                  dy_d     = -ady_c;
                  err_d    = adx_c - ady_c;
                  sx_neg_d = (x1_c < x0_c);
                  sy_neg_d = (y1_c < y0_c);
                  write_d  = (x0_c <= X_LAST) && (y0_c <= Y_LAST);
`endif
               end else begin
                  cur_x_d = ax_lo_c;
                  cur_y_d = ay_lo_c;
                  x_min_d = ax_lo_c;
                  x_end_d = ax_hi_c;
                  y_end_d = ay_hi_c;
                  write_d = !area_empty_c;
               end
            end
         end
         ST_AREA: begin
            if (write_q && fb_ready) begin
               if (at_end_c) begin
                  write_d = 1'b0;
               end else if (cur_x_q == x_end_q) begin
                  cur_x_d = x_min_q;
                  cur_y_d = cur_y_q + CW'(1);
               end else begin
                  cur_x_d = cur_x_q + CW'(1);
               end
            end
         end
         ST_LINE: begin
`ifdef RASTER_LINE_EN
            if (line_adv_c) begin
               if (at_end_c) begin
                  write_d = 1'b0;
               end else begin
                  cur_x_d = step_x_c;
                  cur_y_d = step_y_c;
                  err_d   = err_step_c;
                  write_d = (step_x_c <= X_LAST) && (step_y_c <= Y_LAST);
               end
            end
`else
            write_d = 1'b0;
`endif
         end
         default: write_d = 1'b0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         x_min_q  <= '0;
         x_end_q  <= '0;
         y_end_q  <= '0;
         colour_q <= '0;
         write_q  <= 1'b0;
`ifdef RASTER_LINE_EN
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
`endif
      end else begin
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         x_min_q  <= x_min_d;
         x_end_q  <= x_end_d;
         y_end_q  <= y_end_d;
         colour_q <= colour_d;
         write_q  <= write_d;
`ifdef RASTER_LINE_EN
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
`endif
      end
   end

   assign gpu_busy  = busy_q;
   assign fb_x      = cur_x_q[7:0];
   assign fb_y      = cur_y_q[7:0];
   assign fb_colour = colour_q;
   assign fb_write  = write_q;

endmodule
